// File: rtl/arm_enc_pkg.sv
// Shared types and constants for the instruction-memory encoder:
// request kinds, ALU command codes, op field values and FSM states.
package arm_enc_pkg;

  typedef enum logic [1:0] {
    KIND_DP_REG = 2'b00,
    KIND_DP_IMM = 2'b01,
    KIND_MEM    = 2'b10,
    KIND_BR     = 2'b11
  } kind_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE
  } state_e;

  typedef struct packed {
    kind_e       kind;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic        s;
    logic        l;
    logic [23:0] imm;
  } req_t;

  function automatic logic cmd_legal(input logic [3:0] cmd);
    return cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR};
  endfunction

endpackage

// File: rtl/imem_encoder_if.sv
// Request handshake and instruction-memory write port of the encoder.
// master = request source / memory side, slave = the encoder.
interface imem_encoder_if #(parameter int DEPTH = 64);

  localparam int AW = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [3:0]        req_cond;
  logic [3:0]        req_cmd;
  logic [3:0]        req_rn;
  logic [3:0]        req_rd;
  logic [3:0]        req_rm;
  logic              req_s;
  logic              req_l;
  logic [23:0]       req_imm;
  logic              req_last;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output req_valid, req_kind, req_cond, req_cmd, req_rn, req_rd, req_rm,
           req_s, req_l, req_imm, req_last,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_kind, req_cond, req_cmd, req_rn, req_rd, req_rm,
           req_s, req_l, req_imm, req_last,
    output req_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/instr_field_encoder.sv
// Combinational map of one request to its 32-bit instruction word plus an
// encode-error flag (illegal DP command or immediate out of range).
module instr_field_encoder
  import arm_enc_pkg::*;
(
  input  req_t        req,
  output logic [31:0] word,
  output logic        error
);

  always_comb begin
    word  = '0;
    error = 1'b0;
    case (req.kind)
      KIND_DP_REG: begin
        word  = {req.cond, OP_DP, 1'b0, req.cmd, req.s, req.rn, req.rd, 8'h00, req.rm};
        error = !cmd_legal(req.cmd);
      end
      KIND_DP_IMM: begin
        word  = {req.cond, OP_DP, 1'b1, req.cmd, req.s, req.rn, req.rd, 4'h0, req.imm[7:0]};
        error = !cmd_legal(req.cmd) || (req.imm[23:8] != '0);
      end
      KIND_MEM: begin
        // funct = {0,1,1,0,0,L}: immediate offset, pre-indexed, add
        word  = {req.cond, OP_MEM, 5'b01100, req.l, req.rn, req.rd, req.imm[11:0]};
        error = (req.imm[23:12] != '0);
      end
      default: begin
        word  = {req.cond, OP_BR, 2'b10, req.imm};
      end
    endcase
  end

endmodule

// File: rtl/imem_encoder.sv
// Fills instruction memory from encoded requests; write one cycle after the handshake,
// at most one word per two cycles; ready drops during each write and outside a session.
module imem_encoder
  import arm_enc_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  imem_encoder_if.slave          bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  state_e        state;
  logic [AW-1:0] addr;
  logic          ready;
  logic          last_q;

  req_t          req;
  logic [31:0]   enc_word;
  logic          enc_err;

  assign req = '{
    kind: kind_e'(bus.req_kind),
    cond: bus.req_cond,
    cmd:  bus.req_cmd,
    rn:   bus.req_rn,
    rd:   bus.req_rd,
    rm:   bus.req_rm,
    s:    bus.req_s,
    l:    bus.req_l,
    imm:  bus.req_imm
  };

  instr_field_encoder u_enc (
    .req   (req),
    .word  (enc_word),
    .error (enc_err)
  );

  assign bus.req_ready = ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      ready       <= 1'b0;
      last_q      <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_ACCEPT;
            addr  <= '0;
            count <= '0;
            err   <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (bus.req_valid) begin
            if (enc_err) begin
              // Bad request is consumed without a write; address stays put.
              err <= 1'b1;
              if (bus.req_last) begin
                state <= ST_DONE;
                ready <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              state       <= ST_WRITE;
              ready       <= 1'b0;
              last_q      <= bus.req_last;
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= addr;
              bus.wr_data <= enc_word;
            end
          end
        end
        ST_WRITE: begin
          bus.wr_en <= 1'b0;
          count     <= count + (AW + 1)'(1);
          if (addr != LAST_ADDR) begin
            addr <= addr + AW'(1);
          end
          if (last_q || addr == LAST_ADDR) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ST_ACCEPT;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_encoder.sv
// Self-checking bench: directed sessions, a DEPTH=4 fill, reset during a write,
// and random sessions checked against an arithmetic reference encoder.
module tb_imem_encoder;

  typedef struct {
    int unsigned kind, cond, cmd, rn, rd, rm, s, l, imm, last;
  } tb_req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start4;
  logic        busy, done, err;
  logic        busy4, done4, err4;
  logic [6:0]  count;
  logic [2:0]  count4;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  int          hs4;
  logic [1:0]  a4_q[$];
  logic [31:0] d4_q[$];

  always #5 clk = ~clk;

  imem_encoder_if #(.DEPTH(64)) bus  ();
  imem_encoder_if #(.DEPTH(4))  bus4 ();

  imem_encoder #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  imem_encoder #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .bus(bus4),
    .busy(busy4), .done(done4), .err(err4), .count(count4)
  );

  always @(negedge clk) begin
    if (bus.wr_en) wr_cnt++;
    if (bus4.wr_en) begin
      a4_q.push_back(bus4.wr_addr);
      d4_q.push_back(bus4.wr_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic tb_req_t mk(input int unsigned kind, cond, cmd, rn, rd, rm, s, l, imm, last);
    tb_req_t r;
    r.kind = kind; r.cond = cond; r.cmd = cmd; r.rn = rn; r.rd = rd;
    r.rm = rm; r.s = s; r.l = l; r.imm = imm; r.last = last;
    return r;
  endfunction

  // Reference encoder: word built from the field positions with plain arithmetic.
  function automatic int unsigned ref_word(input tb_req_t r, output bit bad);
    int unsigned w;
    bit ok_cmd;
    ok_cmd = (r.cmd == 4) || (r.cmd == 2) || (r.cmd == 0) || (r.cmd == 12);
    bad = 1'b0;
    w = r.cond << 28;
    case (r.kind)
      0: begin
        bad = !ok_cmd;
        w = w | (r.cmd << 21) | (r.s << 20) | (r.rn << 16) | (r.rd << 12) | r.rm;
      end
      1: begin
        bad = !ok_cmd || (r.imm > 255);
        w = w | (32'd1 << 25) | (r.cmd << 21) | (r.s << 20) | (r.rn << 16) | (r.rd << 12) | (r.imm % 256);
      end
      2: begin
        bad = r.imm > 4095;
        w = w | (32'd1 << 26) | (32'd3 << 23) | (r.l << 20) | (r.rn << 16) | (r.rd << 12) | (r.imm % 4096);
      end
      default: begin
        w = w | (32'd2 << 26) | (32'd2 << 24) | r.imm;
      end
    endcase
    return w;
  endfunction

  function automatic tb_req_t rnd_req();
    tb_req_t r;
    int unsigned legal[4] = '{4, 2, 0, 12};
    r.kind = $urandom_range(3);
    r.cond = $urandom_range(15);
    r.cmd  = ($urandom_range(3) != 0) ? legal[$urandom_range(3)] : $urandom_range(15);
    r.rn   = $urandom_range(15);
    r.rd   = $urandom_range(15);
    r.rm   = $urandom_range(15);
    r.s    = $urandom_range(1);
    r.l    = $urandom_range(1);
    case (r.kind)
      1:       r.imm = ($urandom_range(5) != 0) ? $urandom_range(255)  : $urandom_range(24'hFFFFFF);
      2:       r.imm = ($urandom_range(5) != 0) ? $urandom_range(4095) : $urandom_range(24'hFFFFFF);
      default: r.imm = $urandom_range(24'hFFFFFF);
    endcase
    r.last = 0;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_req(input tb_req_t r);
    bus.req_kind = 2'(r.kind);
    bus.req_cond = 4'(r.cond);
    bus.req_cmd  = 4'(r.cmd);
    bus.req_rn   = 4'(r.rn);
    bus.req_rd   = 4'(r.rd);
    bus.req_rm   = 4'(r.rm);
    bus.req_s    = 1'(r.s);
    bus.req_l    = 1'(r.l);
    bus.req_imm  = 24'(r.imm);
    bus.req_last = 1'(r.last);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Offer one request; returns the write port as seen in the cycle after the handshake.
  task automatic drive(input tb_req_t r, input int gap,
                       output logic en, output logic [5:0] a, output logic [31:0] d);
    int n;
    tick(gap);
    put_req(r);
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick(1);
      n++;
    end
    chk("handshake_ready", 64'(bus.req_ready), 64'(1));
    tick(1);
    bus.req_valid = 1'b0;
    en = bus.wr_en;
    a  = bus.wr_addr;
    d  = bus.wr_data;
  endtask

  task automatic rand_session(input int len);
    tb_req_t     r;
    bit          bad;
    int unsigned w;
    int          exp_addr, exp_cnt, base;
    bit          exp_err;
    logic        en;
    logic [5:0]  a;
    logic [31:0] d;
    exp_addr = 0;
    exp_cnt  = 0;
    exp_err  = 1'b0;
    pulse_start();
    base = wr_cnt;
    for (int i = 0; i < len; i++) begin
      r = rnd_req();
      r.last = (i == len - 1) ? 1 : 0;
      w = ref_word(r, bad);
      drive(r, $urandom_range(2), en, a, d);
      if (bad) begin
        exp_err = 1'b1;
        chk("rnd_err_nowrite", 64'(en), 64'(0));
      end else begin
        chk("rnd_wr_en",   64'(en), 64'(1));
        chk("rnd_wr_addr", 64'(a),  64'(exp_addr));
        chk("rnd_wr_data", 64'(d),  64'(w));
        exp_addr++;
        exp_cnt++;
      end
      chk("rnd_err", 64'(err), 64'(exp_err));
    end
    tick(2);
    chk("rnd_done",   64'(done),          64'(1));
    chk("rnd_busy",   64'(busy),          64'(0));
    chk("rnd_ready",  64'(bus.req_ready), 64'(0));
    chk("rnd_count",  64'(count),         64'(exp_cnt));
    chk("rnd_writes", 64'(wr_cnt - base), 64'(exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        en;
    logic [5:0]  a;
    logic [31:0] d;
    tb_req_t     r;
    bit          bad;

    reset = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    bus.req_valid = 1'b0;
    bus4.req_valid = 1'b0;
    put_req(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus4.req_kind = 2'd1; bus4.req_cond = 4'hE; bus4.req_cmd = 4'd4;
    bus4.req_rn = 4'd2; bus4.req_rd = 4'd1; bus4.req_rm = 4'd0;
    bus4.req_s = 1'b0; bus4.req_l = 1'b0; bus4.req_imm = 24'd0; bus4.req_last = 1'b0;
    tick(3);
    chk("rst_ready",   64'(bus.req_ready), 64'(0));
    chk("rst_wr_en",   64'(bus.wr_en),     64'(0));
    chk("rst_wr_addr", 64'(bus.wr_addr),   64'(0));
    chk("rst_wr_data", 64'(bus.wr_data),   64'(0));
    chk("rst_status",  64'({busy, done, err}), 64'(0));
    chk("rst_count",   64'(count),         64'(0));
    reset = 1'b0;
    tick(2);
    chk("idle_ready", 64'(bus.req_ready), 64'(0));

    // Directed session: ADD imm, SUBS reg, LDR, STR, branch (last)
    pulse_start();
    chk("start_busy", 64'(busy), 64'(1));
    drive(mk(1, 14, 4, 2, 1, 0, 0, 0, 5, 0), 0, en, a, d);
    chk("add_en",   64'(en), 64'(1));
    chk("add_addr", 64'(a),  64'(0));
    chk("add_data", 64'(d),  64'(32'hE2821005));
    tick(1);
    chk("add_en_one_cycle", 64'(bus.wr_en), 64'(0));
    drive(mk(0, 14, 2, 4, 3, 5, 1, 0, 0, 0), 0, en, a, d);
    chk("subs_addr", 64'(a), 64'(1));
    chk("subs_data", 64'(d), 64'(32'hE0543005));
    drive(mk(2, 14, 0, 1, 0, 0, 0, 1, 8, 0), 1, en, a, d);
    chk("ldr_addr", 64'(a), 64'(2));
    chk("ldr_data", 64'(d), 64'(32'hE5910008));
    drive(mk(2, 14, 0, 1, 0, 0, 0, 0, 8, 0), 0, en, a, d);
    chk("str_data", 64'(d), 64'(32'hE5810008));
    drive(mk(3, 14, 0, 0, 0, 0, 0, 0, 2, 1), 0, en, a, d);
    chk("b_addr", 64'(a), 64'(4));
    chk("b_data", 64'(d), 64'(32'hEA000002));
    tick(2);
    chk("s1_done",  64'(done),          64'(1));
    chk("s1_count", 64'(count),         64'(5));
    chk("s1_ready", 64'(bus.req_ready), 64'(0));
    chk("s1_busy",  64'(busy),          64'(0));

    // Out-of-range immediate, then a legal word to the same address; start ignored mid-session
    pulse_start();
    chk("s2_done_clr", 64'(done), 64'(0));
    drive(mk(1, 14, 4, 2, 1, 0, 0, 0, 300, 0), 0, en, a, d);
    chk("imm300_nowrite", 64'(en),  64'(0));
    chk("imm300_err",     64'(err), 64'(1));
    drive(mk(1, 14, 4, 2, 1, 0, 0, 0, 5, 0), 0, en, a, d);
    chk("after_err_addr", 64'(a), 64'(0));
    chk("after_err_data", 64'(d), 64'(32'hE2821005));
    start = 1'b1;
    tick(2);
    start = 1'b0;
    drive(mk(0, 1, 12, 7, 6, 9, 0, 0, 0, 1), 0, en, a, d);
    chk("start_ignored_addr", 64'(a),   64'(1));
    chk("start_ignored_err",  64'(err), 64'(1));
    tick(2);
    chk("s2_count", 64'(count), 64'(2));
    chk("s2_done",  64'(done),  64'(1));

    // DEPTH=4 instance: five requests offered back-to-back
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    bus4.req_valid = 1'b1;
    hs4 = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus4.req_ready) hs4++;
      tick(1);
      bus4.req_imm = 24'(hs4);
    end
    bus4.req_valid = 1'b0;
    chk("d4_handshakes", 64'(hs4),         64'(4));
    chk("d4_writes",     64'(a4_q.size()), 64'(4));
    r = mk(1, 14, 4, 2, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < a4_q.size(); i++) begin
      r.imm = i;
      chk("d4_addr", 64'(a4_q[i]), 64'(i));
      chk("d4_data", 64'(d4_q[i]), 64'(ref_word(r, bad)));
    end
    chk("d4_done",  64'(done4),          64'(1));
    chk("d4_count", 64'(count4),         64'(4));
    chk("d4_ready", 64'(bus4.req_ready), 64'(0));

    // Reset in the middle of a write cycle
    pulse_start();
    drive(mk(1, 14, 4, 2, 1, 0, 0, 0, 5, 0), 0, en, a, d);
    chk("pre_rst_en", 64'(en), 64'(1));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_wr_en",   64'(bus.wr_en),   64'(0));
    chk("mid_rst_wr_addr", 64'(bus.wr_addr), 64'(0));
    chk("mid_rst_wr_data", 64'(bus.wr_data), 64'(0));
    chk("mid_rst_status",  64'({bus.req_ready, busy, done, err}), 64'(0));
    chk("mid_rst_count",   64'(count),       64'(0));
    #1 reset = 1'b0;
    tick(1);
    pulse_start();
    drive(mk(0, 14, 2, 4, 3, 5, 1, 0, 0, 1), 0, en, a, d);
    chk("post_rst_addr", 64'(a), 64'(0));
    chk("post_rst_data", 64'(d), 64'(32'hE0543005));
    tick(2);
    chk("post_rst_count", 64'(count), 64'(1));

    for (int s = 0; s < 25; s++) begin
      rand_session($urandom_range(12, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_encoder.md
IMEM_ENCODER -- requirements
Module: imem_encoder

Interface
REQ-001 Parameter DEPTH, default 64, the number of instruction-memory words the block can fill (power of two, 2..256).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begins a fill session at address 0; honoured only in IDLE or DONE.
REQ-005 req_valid / req_ready  input / output  1 / 1  request handshake; a transfer occurs on a clock edge where both are 1.
REQ-006 req_kind  input  2  request kind: 00 DP-register, 01 DP-immediate, 10 memory, 11 branch.
REQ-007 req_cond, req_cmd, req_rn, req_rd, req_rm  input  4 each  condition, ALU command, and register fields.
REQ-008 req_s, req_l  input  1 each  S flag (DP kinds); load=1 / store=0 (memory kind).
REQ-009 req_imm  input  24  immediate or branch offset; req_last  input  1  marks the final request of the session.
REQ-010 wr_en, wr_addr, wr_data  output  1 / clog2(DEPTH) / 32  instruction-memory write port.
REQ-011 busy, done, err  output  1 each  session active, session finished, sticky encode error.
REQ-012 count  output  clog2(DEPTH)+1  number of words written in the current session.

Function
REQ-013 Output word format: [31:28]=cond, [27:26]=op, [25:20]=funct, [19:16]=Rn, [15:12]=Rd, [11:0]=Src2.
REQ-014 DP-register: op=00, funct={0, cmd, S}, Src2={8'b0, Rm}.
REQ-015 DP-immediate: op=00, funct={1, cmd, S}, Src2={4'b0, imm[7:0]}.
REQ-016 Memory: op=01, funct={0,1,1,0,0,L}, Src2=imm[11:0].
REQ-017 Branch: op=10, bits[25:24]=10, bits[23:0]=imm[23:0].
REQ-018 Legal cmd values for DP kinds: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
REQ-019 Error conditions: DP kind with any other cmd; DP-immediate with imm>255; memory with imm>4095.
REQ-020 On an error request: set err, write nothing, leave the address unchanged, and still consume the request.
REQ-021 State machine, IDLE: ready=0, busy=0; start -> ACCEPT, clearing address, count and err.
REQ-022 ACCEPT: ready=1; on a valid request, register the encoded word and go to WRITE, or stay in ACCEPT if the request is an error.
REQ-023 WRITE: ready=0, wr_en=1 for exactly one cycle with the registered addr/data; then address+1 and count+1.
REQ-024 WRITE exit: to DONE if req_last was set or the address written was DEPTH-1, otherwise back to ACCEPT.
REQ-025 An error request carrying req_last goes ACCEPT -> DONE directly.
REQ-026 DONE: done=1, ready=0; start -> ACCEPT (new session).
REQ-027 Latency: handshake at edge N gives wr_en=1 in cycle N+1; maximum throughput is one word per 2 cycles.
REQ-028 The address never wraps; requests are never accepted after DEPTH writes.
REQ-029 start is ignored in ACCEPT and WRITE.
REQ-030 busy=1 in ACCEPT and WRITE.

Reset
REQ-031 Reset, at any time including mid-WRITE, forces IDLE with ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, count=0.
REQ-032 A write in progress at reset is dropped.

Structure
REQ-033 Shared package arm_enc_pkg holds the kind enum, the cmd constants (ADD/SUB/AND/ORR), the op constants and the state enum.
REQ-034 A combinational sub-module instr_field_encoder maps request fields to {word, error}; imem_encoder holds the FSM, counters and output registers.

Verification
REQ-035 start, then ADD R1,R2,#5 (kind 01, cond E, S=0) -> wr_data=0xE2821005 at addr 0, one cycle after the handshake.
REQ-036 SUBS R3,R4,R5 (kind 00, S=1) -> 0xE0543005; LDR R0,[R1,#8] -> 0xE5910008; STR with the same fields -> 0xE5810008.
REQ-037 Branch, cond E, imm=0x000002, req_last=1 -> 0xEA000002 written, then done=1, count reflects all words, ready=0.
REQ-038 DP-immediate with imm=300, then a legal request -> err=1, the first request writes nothing, and the legal word goes to the same address.
REQ-039 DEPTH=4 with 5 requests offered back-to-back -> 4 writes (addr 0..3), done=1, the fifth request never sees ready=1.
REQ-040 reset asserted during WRITE -> wr_en falls immediately, all outputs 0; a following start fills from addr 0.
